// File: rtl/id_exe_regfile.sv
// Single-cycle decode/execute slice: eight-entry register file, ALU, optional shifter, NZCV status.
// Build option: define ID_EXE_SHIFT_EN to implement LSL/LSR; otherwise those ops decode as NOP.
module id_exe_regfile (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instruction,
    output logic [31:0] result,
    output logic        write_enable,
    output logic [2:0]  write_addr,
    output logic [31:0] cpsr,
    input  logic [2:0]  dbg_addr,
    output logic [31:0] dbg_data
);

    localparam logic [2:0] OP_MOV  = 3'b000;
    localparam logic [2:0] OP_MOVT = 3'b001;
    localparam logic [2:0] OP_CLR  = 3'b010;
    localparam logic [2:0] OP_LSL  = 3'b100;
    localparam logic [2:0] OP_LSR  = 3'b101;

    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;
    localparam logic [2:0] OP_AND  = 3'b011;
    localparam logic [2:0] OP_ORR  = 3'b100;
    localparam logic [2:0] OP_EOR  = 3'b101;

    logic [31:0] regs_q [8];
    logic [31:0] regs_d [8];
    logic [3:0]  nzcv_q;
    logic [3:0]  nzcv_d;

    logic        f_nop;
    logic        f_reg;
    logic        f_arith;
    logic        f_set;
    logic [2:0]  f_op;
    logic [2:0]  f_rd;
    logic [2:0]  f_rn;
    logic [2:0]  f_rm;
    logic [15:0] f_imm;

    assign f_nop   = instruction[31];
    assign f_reg   = instruction[30];
    assign f_arith = instruction[29];
    assign f_set   = instruction[28];
    assign f_op    = instruction[27:25];
    assign f_rd    = instruction[24:22];
    assign f_rn    = instruction[21:19];
    assign f_rm    = instruction[18:16];
    assign f_imm   = instruction[15:0];

    logic [2:0]  rn_addr;
    logic [31:0] rn_val;
    logic [31:0] rm_val;
    logic [31:0] op2;
    logic [32:0] sum;
    logic [32:0] diff;

    // MOVT needs the old Rd, so the Rn read port is steered to Rd for that op.
    assign rn_addr = (!f_arith && f_op == OP_MOVT) ? f_rd : f_rn;
    assign rn_val  = regs_q[rn_addr];
    assign rm_val  = regs_q[f_rm];
    assign op2     = f_reg ? rm_val : {16'b0, f_imm};
    assign sum     = {1'b0, rn_val} + {1'b0, op2};
    assign diff    = {1'b0, rn_val} - {1'b0, op2};

    logic [31:0] result_c;
    logic        we_c;
    logic        flag_we_c;
    logic        carry_c;
    logic        ovf_c;
    logic        logic_op_c;

    always_comb begin
        result_c   = '0;
        we_c       = 1'b0;
        flag_we_c  = 1'b0;
        carry_c    = 1'b0;
        ovf_c      = 1'b0;
        logic_op_c = 1'b0;
        if (!f_nop) begin
            if (!f_arith) begin
                case (f_op)
                    OP_MOV: begin
                        result_c = {16'b0, f_imm};
                        we_c     = 1'b1;
                    end
                    OP_MOVT: begin
                        result_c = {f_imm, rn_val[15:0]};
                        we_c     = 1'b1;
                    end
                    OP_CLR: begin
                        result_c = '0;
                        we_c     = 1'b1;
                    end
`ifdef ID_EXE_SHIFT_EN
                    OP_LSL: begin
                        result_c = rn_val << op2[4:0];
                        we_c     = 1'b1;
                    end
                    OP_LSR: begin
                        result_c = rn_val >> op2[4:0];
                        we_c     = 1'b1;
                    end
`endif
                    default: begin
                        result_c = '0;
                        we_c     = 1'b0;
                    end
                endcase
            end else begin
                case (f_op)
                    OP_ADD: begin
                        result_c = sum[31:0];
                        we_c     = 1'b1;
                        carry_c  = sum[32];
                        ovf_c    = (rn_val[31] == op2[31]) && (sum[31] != rn_val[31]);
                    end
                    OP_SUB: begin
                        result_c = diff[31:0];
                        we_c     = 1'b1;
                        // Borrow appears in bit 32; carry is its inverse.
                        carry_c  = ~diff[32];
                        ovf_c    = (rn_val[31] != op2[31]) && (diff[31] != rn_val[31]);
                    end
                    OP_AND: begin
                        result_c   = rn_val & op2;
                        we_c       = 1'b1;
                        logic_op_c = 1'b1;
                    end
                    OP_ORR: begin
                        result_c   = rn_val | op2;
                        we_c       = 1'b1;
                        logic_op_c = 1'b1;
                    end
                    OP_EOR: begin
                        result_c   = rn_val ^ op2;
                        we_c       = 1'b1;
                        logic_op_c = 1'b1;
                    end
                    default: begin
                        result_c = '0;
                        we_c     = 1'b0;
                    end
                endcase
                flag_we_c = we_c && f_set;
            end
        end
    end

    always_comb begin
        nzcv_d = nzcv_q;
        if (flag_we_c) begin
            nzcv_d[3] = result_c[31];
            nzcv_d[2] = (result_c == 32'd0);
            if (!logic_op_c) begin
                nzcv_d[1] = carry_c;
                nzcv_d[0] = ovf_c;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            nzcv_q <= 4'b0000;
        end else begin
            nzcv_q <= nzcv_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_reg
            always_comb begin
                regs_d[gi] = regs_q[gi];
                if (we_c && f_rd == 3'(gi)) begin
                    regs_d[gi] = result_c;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    regs_q[gi] <= '0;
                end else begin
                    regs_q[gi] <= regs_d[gi];
                end
            end
        end
    endgenerate

    assign result       = result_c;
    assign write_enable = we_c;
    assign write_addr   = f_rd;
    assign cpsr         = {nzcv_q, 28'b0};
    assign dbg_data     = regs_q[dbg_addr];

endmodule

// File: tb/tb_id_exe_regfile.sv
// Vector-table bench for id_exe_regfile with a post-edge state scoreboard.
module tb_id_exe_regfile;

    logic        clk;
    logic        rst;
    logic [31:0] instruction;
    logic [31:0] result;
    logic        write_enable;
    logic [2:0]  write_addr;
    logic [31:0] cpsr;
    logic [2:0]  dbg_addr;
    logic [31:0] dbg_data;

    id_exe_regfile dut (
        .clk          (clk),
        .rst          (rst),
        .instruction  (instruction),
        .result       (result),
        .write_enable (write_enable),
        .write_addr   (write_addr),
        .cpsr         (cpsr),
        .dbg_addr     (dbg_addr),
        .dbg_data     (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic        rst;
        logic [31:0] res;
        logic        we;
        logic [2:0]  wa;
        logic [2:0]  chk;
        logic [31:0] reg_val;
        logic [31:0] cpsr;
    } vec_t;

    typedef struct {
        int          idx;
        logic [2:0]  chk;
        logic [31:0] reg_val;
        logic [31:0] cpsr;
    } exp_t;

    localparam int NVEC = 21;
    vec_t vecs [NVEC];
    exp_t sb [$];

    int checks;
    int failures;

    task automatic check32(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s vec=%0d actual=%08h required=%08h", name, idx, act, exp);
        end
    endtask

    task automatic apply(input int idx, input vec_t v);
        exp_t e;
        @(negedge clk);
        instruction = v.instr;
        rst         = v.rst;
        dbg_addr    = v.chk;
        #1;
        check32("result", idx, result, v.res);
        check32("write_enable", idx, {31'b0, write_enable}, {31'b0, v.we});
        check32("write_addr", idx, {29'b0, write_addr}, {29'b0, v.wa});
        e.idx = idx; e.chk = v.chk; e.reg_val = v.reg_val; e.cpsr = v.cpsr;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_empty vec=%0d actual=0 required=1", idx);
        end else begin
            e = sb.pop_front();
            check32("reg", e.idx, dbg_data, e.reg_val);
            check32("cpsr", e.idx, cpsr, e.cpsr);
        end
        $display("vec %0d instr=%08h rst=%0b result=%08h we=%0b wa=%0d r%0d=%08h cpsr=%08h",
                 idx, v.instr, v.rst, result, write_enable, write_addr, v.chk, dbg_data, cpsr);
    endtask

    initial begin
        logic [31:0] sh_l_res;
        logic [31:0] sh_r_res;
        logic [31:0] sh_l_reg;
        logic        sh_we;
        checks   = 0;
        failures = 0;
`ifdef ID_EXE_SHIFT_EN
        sh_l_res = 32'd2; sh_r_res = 32'd1; sh_l_reg = 32'd2; sh_we = 1'b1;
`else
        sh_l_res = 32'd0; sh_r_res = 32'd0; sh_l_reg = 32'd1; sh_we = 1'b0;
`endif
        //           instr          rst   result        we    wa    chk   reg           cpsr
        vecs[0]  = '{32'h04000000, 1'b0, 32'h00000000, 1'b1, 3'd0, 3'd0, 32'h00000000, 32'h00000000};
        vecs[1]  = '{32'h04400000, 1'b0, 32'h00000000, 1'b1, 3'd1, 3'd1, 32'h00000000, 32'h00000000};
        vecs[2]  = '{32'h32000000, 1'b0, 32'h00000000, 1'b1, 3'd0, 3'd0, 32'h00000000, 32'h40000000};
        vecs[3]  = '{32'h34000001, 1'b0, 32'hFFFFFFFF, 1'b1, 3'd0, 3'd0, 32'hFFFFFFFF, 32'h80000000};
        vecs[4]  = '{32'h0000FFFF, 1'b0, 32'h0000FFFF, 1'b1, 3'd0, 3'd0, 32'h0000FFFF, 32'h80000000};
        vecs[5]  = '{32'h0200FFFF, 1'b0, 32'hFFFFFFFF, 1'b1, 3'd0, 3'd0, 32'hFFFFFFFF, 32'h80000000};
        vecs[6]  = '{32'h32000001, 1'b0, 32'h00000000, 1'b1, 3'd0, 3'd0, 32'h00000000, 32'h60000000};
        vecs[7]  = '{32'h00000001, 1'b0, 32'h00000001, 1'b1, 3'd0, 3'd0, 32'h00000001, 32'h60000000};
        vecs[8]  = '{32'h08000001, 1'b0, sh_l_res,     sh_we, 3'd0, 3'd0, sh_l_reg,    32'h60000000};
        vecs[9]  = '{32'h0A000001, 1'b0, sh_r_res,     sh_we, 3'd0, 3'd0, 32'h00000001, 32'h60000000};
        vecs[10] = '{32'h0040FFFF, 1'b0, 32'h0000FFFF, 1'b1, 3'd1, 3'd1, 32'h0000FFFF, 32'h60000000};
        vecs[11] = '{32'h02487FFF, 1'b0, 32'h7FFFFFFF, 1'b1, 3'd1, 3'd1, 32'h7FFFFFFF, 32'h60000000};
        vecs[12] = '{32'h72890000, 1'b0, 32'hFFFFFFFE, 1'b1, 3'd2, 3'd2, 32'hFFFFFFFE, 32'h90000000};
        vecs[13] = '{32'h22C80001, 1'b0, 32'h80000000, 1'b1, 3'd3, 3'd3, 32'h80000000, 32'h90000000};
        vecs[14] = '{32'hA2C80001, 1'b0, 32'h00000000, 1'b0, 3'd3, 3'd3, 32'h80000000, 32'h90000000};
        vecs[15] = '{32'h3708FFFF, 1'b0, 32'h0000FFFF, 1'b1, 3'd4, 3'd4, 32'h0000FFFF, 32'h10000000};
        vecs[16] = '{32'h7B490000, 1'b0, 32'h00000000, 1'b1, 3'd5, 3'd5, 32'h00000000, 32'h50000000};
        vecs[17] = '{32'h29980F00, 1'b0, 32'h80000F00, 1'b1, 3'd6, 3'd6, 32'h80000F00, 32'h50000000};
        vecs[18] = '{32'h75CB0000, 1'b0, 32'hFFFFFFFF, 1'b1, 3'd7, 3'd7, 32'hFFFFFFFF, 32'h90000000};
        vecs[19] = '{32'h31C00005, 1'b0, 32'h00000000, 1'b0, 3'd7, 3'd7, 32'hFFFFFFFF, 32'h90000000};
        vecs[20] = '{32'h32C80001, 1'b1, 32'h80000000, 1'b1, 3'd3, 3'd3, 32'h00000000, 32'h00000000};

        // Unknown instruction held during reset must leave clean state.
        instruction = 'x;
        rst         = 1'b1;
        dbg_addr    = 3'd0;
        repeat (3) @(posedge clk);
        #1;
        for (int r = 0; r < 8; r++) begin
            dbg_addr = 3'(r);
            #1;
            check32("reset_reg", r, dbg_data, 32'h0);
        end
        check32("reset_cpsr", 0, cpsr, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            apply(i, vecs[i]);
        end

        // After the reset-with-ADDS vector every register must read zero.
        @(negedge clk);
        rst         = 1'b0;
        instruction = 32'h80000000;
        for (int r = 0; r < 8; r++) begin
            dbg_addr = 3'(r);
            #1;
            check32("post_reset_reg", r, dbg_data, 32'h0);
        end
        check32("post_reset_cpsr", 0, cpsr, 32'h0);

        // A flag-setting op after reset starts from a clean CPSR.
        @(negedge clk);
        instruction = 32'h34000001;
        dbg_addr    = 3'd0;
        @(posedge clk);
        #1;
        check32("post_reset_subs_reg", 0, dbg_data, 32'hFFFFFFFF);
        check32("post_reset_subs_cpsr", 0, cpsr, 32'h80000000);

        check32("scoreboard_drained", 0, sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
